uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: the number of clock cycles in each serial bit period (minimum 2).
REQ-002 The block SHALL have parameter DATA_BITS, default 8: the number of payload bits per frame (5 to 9).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port send, input, 1 bit: transmit request, sampled only while ready=1.
REQ-006 The block SHALL have port data, input, DATA_BITS bits: payload, captured on the accepting edge.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, registered, idle level 1.
REQ-008 The block SHALL have port ready, output, 1 bit: the block is idle and can accept send.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP.
REQ-011 ready SHALL be 1 if and only if the state is IDLE.
REQ-012 In IDLE, a rising edge with send=1 SHALL capture data into an internal shift register, clear the bit-period counter and bit index, and enter START.
REQ-013 An edge with send=1 and ready=0 SHALL be ignored, and changes on data while ready=0 SHALL not affect the frame in flight.
REQ-014 tx SHALL be 1 in IDLE, 0 in START, the current payload bit in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a counter that counts 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-016 DATA SHALL transmit the payload LSB first, using DATA_BITS bit periods tracked by a bit index 0..DATA_BITS-1.
REQ-017 On completing the last DATA bit, the FSM SHALL go to PARITY when parity is compiled in, and to STOP otherwise.
REQ-018 On completing STOP, the FSM SHALL return to IDLE.
REQ-019 done SHALL be 1 for exactly the first IDLE cycle after STOP, coincident with ready returning to 1.
REQ-020 A send=1 during that done cycle SHALL be accepted, giving back-to-back frames separated by exactly one idle cycle with tx=1.
REQ-021 Latency SHALL be: accepting edge at cycle 0; START occupies cycles 1..CLKS_PER_BIT; frame length F = (2 + DATA_BITS + P) x CLKS_PER_BIT cycles, where P is 1 with parity and 0 without; done occurs at cycle F+1.

Reset
REQ-022 Asserting reset SHALL immediately, regardless of clock, force state=IDLE, tx=1, ready=1, done=0, and clear all counters and the shift register.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-024 After reset deasserts, the first send SHALL start a clean frame with no residue from the aborted frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL include the PARITY state and transmit even parity (XOR of the DATA_BITS payload bits) between DATA and STOP.
REQ-026 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and DATA SHALL transition directly to STOP.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-027 No parity: reset, then send=1 with data=0x55 for one cycle -> tx holds 0 for cycles 1-4; then 1,0,1,0,1,0,1,0, each for 4 cycles (cycles 5-36); then 1 for cycles 37-40; done=1 and ready=1 at cycle 41 only.
REQ-028 UART_TX_PARITY_EN defined: send data=0x07 -> parity bit 1 during cycles 37-40; stop bit during cycles 41-44; done at cycle 45. With data=0x55 -> parity bit 0.
REQ-029 send held at 1 with data 0xA3 then 0x3C -> two frames with exactly one tx=1 idle cycle between them (the done cycle), both payloads correct, two done pulses.
REQ-030 send pulsed during cycle 10 of a frame, with data changed to 0xFF -> no effect on the current frame and no second frame.
REQ-031 reset asserted between clock edges at cycle 20 -> tx=1 and ready=1 immediately, no done pulse; a subsequent send of 0x81 produces a correct full frame.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial transmitter: start, LSB-first payload, optional even parity, stop
// Optional parity stage is built when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic bit_end;
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      ready     <= 1'b1;
      done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            shift_reg <= data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
            cnt     <= '0;
            bit_idx <= '0;
            state   <= START;
            tx      <= 1'b0;
            ready   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= shift_reg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // tx is registered, so present the next bit before shifting it down
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            tx    <= 1'b1;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a bit-slot frame model
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F = (2 + DB + PAR) * CPB;

  logic          clock;
  logic          reset;
  logic          send;
  logic [DB-1:0] data;
  logic          tx;
  logic          ready;
  logic          done;

  int total;
  int bad;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clock(clock),
    .reset(reset),
    .send (send),
    .data (data),
    .tx   (tx),
    .ready(ready),
    .done (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level during frame cycle i+1: slot 0 start, slots 1..DB payload LSB first, parity, stop
  function automatic logic exp_bit(input int i, input logic [DB-1:0] d);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DB) return d[slot-1];
    if (PAR == 1 && slot == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [DB-1:0] d);
    send = 1'b1;
    data = d;
  endtask

  task automatic watch_frame(input logic [DB-1:0] d, input bit keep, input logic [DB-1:0] nxt);
    for (int c = 1; c <= F; c++) begin
      @(negedge clock);
      if (!keep) send = (c == 10);
      data = (!keep && c == 10) ? {DB{1'b1}} : DB'($urandom);
      check("tx", tx, exp_bit(c - 1, d));
      check("ready_busy", ready, 1'b0);
      check("done_busy", done, 1'b0);
    end
    @(negedge clock);
    check("done_pulse", done, 1'b1);
    check("ready_back", ready, 1'b1);
    check("tx_gap", tx, 1'b1);
    if (keep) data = nxt;
    else send = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check("idle_tx", tx, 1'b1);
      check("idle_ready", ready, 1'b1);
      check("idle_done", done, 1'b0);
    end
  endtask

  initial begin
    logic [DB-1:0] dir [4];
    logic [DB-1:0] d;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    send  = 1'b0;
    data  = '0;
    dir[0] = 8'h55;
    dir[1] = 8'h07;
    dir[2] = 8'h00;
    dir[3] = 8'hFF;

    repeat (2) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      start_frame(dir[i]);
      watch_frame(dir[i], 1'b0, '0);
      idle(1);
    end

    start_frame(8'hA3);
    watch_frame(8'hA3, 1'b1, 8'h3C);
    watch_frame(8'h3C, 1'b0, '0);
    idle(3);

    start_frame(8'h5A);
    @(negedge clock);
    send = 1'b0;
    repeat (19) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    @(negedge clock);
    check("abort_done_hold", done, 1'b0);
    reset = 1'b0;
    idle(2);
    start_frame(8'h81);
    watch_frame(8'h81, 1'b0, '0);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      d = DB'($urandom);
      start_frame(d);
      watch_frame(d, 1'b0, '0);
      idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
